comparator_share_ctrl: RTL and testbench

//  Shares one 4-bit magnitude comparator (A/B in; A_gt_B/A_lt_B/A_eq_B out) among N requesters.

---
 rtl/comparator_ctrl_pkg.sv | 20 ++
 rtl/comparator_share_ctrl_rr_arbiter.sv | 33 +++
 rtl/comparator_share_ctrl.sv | 108 ++++++++++
 tb/tb_comparator_share_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_ctrl_pkg.sv
// rtl/comparator_ctrl_pkg.sv - shared types and helpers for the comparator share controller
package comparator_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } ctrl_state_t;

    localparam int DW_DEF = 4;

    // A healthy comparator asserts exactly one of its three flags.
    function automatic logic onehot3(input logic gt, input logic lt, input logic eq);
        case ({gt, lt, eq})
            3'b100, 3'b010, 3'b001: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/comparator_share_ctrl_rr_arbiter.sv
// rtl/comparator_share_ctrl_rr_arbiter.sv - round-robin grant search starting at ptr
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        gnt     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = IDX_W'(idx);
            end
        end
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/comparator_share_ctrl.sv
// rtl/comparator_share_ctrl.sv - shares one magnitude comparator among N_REQ requesters
module comparator_share_ctrl
    import comparator_ctrl_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int DW    = DW_DEF,
    parameter  int CNT_W = 16,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    output logic [N_REQ-1:0]    req_ready,
    output logic [DW-1:0]       cmp_a,
    output logic [DW-1:0]       cmp_b,
    input  logic                cmp_gt,
    input  logic                cmp_lt,
    input  logic                cmp_eq,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic                rsp_gt,
    output logic                rsp_lt,
    output logic                rsp_eq,
    output logic                cmp_err,
    output logic [CNT_W-1:0]    done_cnt
);

    ctrl_state_t      state_q;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  id_q;
    logic [DW-1:0]    cmp_a_q, cmp_b_q;
    logic             rsp_valid_q, rsp_gt_q, rsp_lt_q, rsp_eq_q;
    logic             err_q;
    logic [CNT_W-1:0] done_q;
    logic [ID_W-1:0]  gnt_idx;
    logic             accept;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .en      (state_q == IDLE),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx)
    );

    assign accept   = |(req_valid & req_ready);
    assign rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_gt_q    <= 1'b0;
            rsp_lt_q    <= 1'b0;
            rsp_eq_q    <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cmp_a_q  <= req_a[int'(gnt_idx)*DW +: DW];
                        cmp_b_q  <= req_b[int'(gnt_idx)*DW +: DW];
                        id_q     <= gnt_idx;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= CMP;
                    end
                end
                CMP: begin
                    rsp_gt_q    <= cmp_gt;
                    rsp_lt_q    <= cmp_lt;
                    rsp_eq_q    <= cmp_eq;
                    if (!onehot3(cmp_gt, cmp_lt, cmp_eq)) begin
                        err_q <= 1'b1;
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        done_q      <= done_q + CNT_W'(1);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmp_a     = cmp_a_q;
    assign cmp_b     = cmp_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_gt    = rsp_gt_q;
    assign rsp_lt    = rsp_lt_q;
    assign rsp_eq    = rsp_eq_q;
    assign cmp_err   = err_q;
    assign done_cnt  = done_q;

endmodule

// File: tb/tb_comparator_share_ctrl.sv
// tb/tb_comparator_share_ctrl.sv - self-checking bench for comparator_share_ctrl
module tb_comparator_share_ctrl;

    localparam int N  = 4;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic            rsp_ready = 1'b0;
    logic            fault = 1'b0;

    logic [N-1:0]  req_ready, w_req_ready;
    logic [DW-1:0] cmp_a, cmp_b, w_cmp_a, w_cmp_b;
    logic          cmp_gt, cmp_lt, cmp_eq, w_cmp_gt, w_cmp_lt, w_cmp_eq;
    logic          rsp_valid, rsp_gt, rsp_lt, rsp_eq, cmp_err;
    logic          w_rsp_valid, w_rsp_gt, w_rsp_lt, w_rsp_eq, w_cmp_err;
    logic [1:0]    rsp_id, w_rsp_id;
    logic [15:0]   done_cnt;
    logic [1:0]    w_done_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Real 4-bit comparators; fault forces gt and lt high together.
    assign cmp_gt   = fault | (cmp_a > cmp_b);
    assign cmp_lt   = fault | (cmp_a < cmp_b);
    assign cmp_eq   = (cmp_a == cmp_b);
    assign w_cmp_gt = fault | (w_cmp_a > w_cmp_b);
    assign w_cmp_lt = fault | (w_cmp_a < w_cmp_b);
    assign w_cmp_eq = (w_cmp_a == w_cmp_b);

    comparator_share_ctrl #(.N_REQ(N), .DW(DW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_gt(rsp_gt), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq),
        .cmp_err(cmp_err), .done_cnt(done_cnt)
    );

    comparator_share_ctrl #(.N_REQ(N), .DW(DW), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(w_req_ready), .cmp_a(w_cmp_a), .cmp_b(w_cmp_b),
        .cmp_gt(w_cmp_gt), .cmp_lt(w_cmp_lt), .cmp_eq(w_cmp_eq),
        .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w_rsp_id),
        .rsp_gt(w_rsp_gt), .rsp_lt(w_rsp_lt), .rsp_eq(w_rsp_eq),
        .cmp_err(w_cmp_err), .done_cnt(w_done_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: phase 0 waiting, 1 comparing, 2 answering.
    int   m_phase = 0, m_ptr = 0, m_id = 0, m_a = 0, m_b = 0, m_cnt = 0;
    logic m_gt = 0, m_lt = 0, m_eq = 0, m_err = 0;

    always @(negedge clk) begin
        int g;
        logic [N-1:0] er;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        er = (m_phase == 0 && g >= 0) ? (4'b0001 << g) : 4'b0000;

        chk("req_ready", req_ready, er);
        chk("rsp_valid", rsp_valid, m_phase == 2);
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_flags", {rsp_gt, rsp_lt, rsp_eq}, {m_gt, m_lt, m_eq});
        chk("cmp_ops", {cmp_a, cmp_b}, {m_a[3:0], m_b[3:0]});
        chk("cmp_err", cmp_err, m_err);
        chk("done_cnt", done_cnt, m_cnt % 65536);
        chk("w_done_cnt", w_done_cnt, m_cnt % 4);
        chk("w_rsp", {w_req_ready, w_rsp_valid, w_rsp_id, w_cmp_err},
            {er, m_phase == 2, m_id[1:0], m_err});

        if (!rst_n) begin
            m_phase = 0; m_ptr = 0; m_id = 0; m_a = 0; m_b = 0; m_cnt = 0;
            m_gt = 0; m_lt = 0; m_eq = 0; m_err = 0;
        end else if (m_phase == 0) begin
            if (g >= 0) begin
                m_a = int'(req_a[g*DW +: DW]);
                m_b = int'(req_b[g*DW +: DW]);
                m_id = g;
                m_ptr = (g + 1) % N;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_gt = fault | (m_a > m_b);
            m_lt = fault | (m_a < m_b);
            m_eq = (m_a == m_b);
            if ((int'(m_gt) + int'(m_lt) + int'(m_eq)) != 1) m_err = 1'b1;
            m_phase = 2;
        end else if (rsp_ready) begin
            m_cnt++;
            m_phase = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic issue(input int id, input int a, input int b);
        bit got;
        got = 1'b0;
        step();
        req_a[id*DW +: DW] = a[3:0];
        req_b[id*DW +: DW] = b[3:0];
        req_valid[id] = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            got = req_ready[id];
            step();
        end
        chk("accept_timeout", got, 1);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp();
        bit got;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        chk("rsp_timeout", got, 1);
    endtask

    initial begin
        int order[5];
        int n;
        order = '{0, 1, 2, 3, 0};

        step();
        step();
        @(negedge clk);
        chk("rst_outputs", {rsp_valid, cmp_err, done_cnt}, 18'h0);
        step();
        rst_n = 1'b1;

        // Single request: 9 vs 3 from requester 2
        rsp_ready = 1'b1;
        issue(2, 9, 3);
        @(negedge clk);
        chk("t1_no_early_rsp", rsp_valid, 0);
        step();
        @(negedge clk);
        chk("t1_rsp", {rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq}, {1'b1, 2'd2, 3'b100});
        step();
        @(negedge clk);
        chk("t1_done", {rsp_valid, done_cnt}, {1'b0, 16'd1});

        // All four valid, A=B=5, rotating grants
        do_rst();
        req_a = {4{4'd5}};
        req_b = {4{4'd5}};
        req_valid = 4'hf;
        n = 0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                chk("t2_order", rsp_id, order[n]);
                chk("t2_eq", rsp_eq, 1);
                n++;
            end
        end
        chk("t2_count", n, 5);
        step();
        req_valid = '0;
        repeat (4) step();

        // Back-pressure: 0 vs 15 held while consumer stalls
        rsp_ready = 1'b0;
        issue(1, 0, 15);
        req_a[3*DW +: DW] = 4'd1;
        req_b[3*DW +: DW] = 4'd1;
        req_valid[3] = 1'b1;
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold", {rsp_valid, rsp_id, rsp_lt, req_ready}, {1'b1, 2'd1, 1'b1, 4'b0000});
            @(negedge clk);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_still_valid", rsp_valid, 1);
        step();
        @(negedge clk);
        chk("t3_released", {rsp_valid, req_ready}, {1'b0, 4'b1000});
        step();
        req_valid[3] = 1'b0;
        repeat (4) step();

        // Fault: gt and lt both high, error must stick
        fault = 1'b1;
        issue(0, 7, 2);
        wait_rsp();
        chk("t4_err_set", {cmp_err, rsp_gt, rsp_lt}, 3'b111);
        step();
        fault = 1'b0;
        for (int k = 0; k < 3; k++) begin
            issue(k + 1, k, 3);
            wait_rsp();
            chk("t4_err_sticky", cmp_err, 1);
        end
        do_rst();
        @(negedge clk);
        chk("t4_err_cleared", cmp_err, 0);

        // Reset while comparing
        issue(2, 4, 4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_after_rst", {rsp_valid, done_cnt}, 17'h0);
        step();
        req_a[0*DW +: DW] = 4'd6;
        req_b[0*DW +: DW] = 4'd8;
        req_valid = 4'b0101;
        @(negedge clk);
        chk("t5_grant0", req_ready, 4'b0001);
        step();
        req_valid = '0;
        wait_rsp();
        chk("t5_rsp", {rsp_id, rsp_gt, rsp_lt, rsp_eq}, {2'd0, 3'b010});

        // Counter wrap on the 2-bit instance
        do_rst();
        for (int k = 0; k < 5; k++) begin
            issue(k % 4, k, 15 - k);
            wait_rsp();
        end
        step();
        @(negedge clk);
        chk("t6_wrap", {w_done_cnt, done_cnt}, {2'd1, 16'd5});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
